// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: widths, entry layout and the
// CDB snoop helper used by both dispatch forwarding and wakeup.
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_IDX_W  = 4;
    localparam int DATA_W    = 32;
    localparam int OPENUM_W  = 6;
    localparam int OPTYPE_W  = 4;
    localparam int ROB_IDX_W = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [OPENUM_W-1:0]  OPENUM_TYPE;
    typedef logic [OPTYPE_W-1:0]  OP_TYPE;
    typedef logic [ROB_IDX_W-1:0] ROB_INDEX_TYPE;
    typedef logic [DATA_W-1:0]    DATA_TYPE;
    typedef logic [DATA_W-1:0]    ADDR_TYPE;

    typedef struct packed {
        logic          pend;
        DATA_TYPE      val;
    } operand_t;

    typedef struct packed {
        logic          busy;
        OPENUM_TYPE    op;
        OP_TYPE        opType;
        DATA_TYPE      vj;
        logic          qj_pend;
        ROB_INDEX_TYPE qj;
        DATA_TYPE      vk;
        logic          qk_pend;
        ROB_INDEX_TYPE qk;
        ROB_INDEX_TYPE rob;
        ADDR_TYPE      pc;
        DATA_TYPE      imm;
    } rs_entry_t;

    // A pending operand captures a matching broadcast; LSB is checked last so it wins a tag collision.
    function automatic operand_t snoop(
        input logic          pend,
        input DATA_TYPE      val,
        input ROB_INDEX_TYPE tag,
        input logic          aluV,
        input ROB_INDEX_TYPE aluTag,
        input DATA_TYPE      aluVal,
        input logic          lsbV,
        input ROB_INDEX_TYPE lsbTag,
        input DATA_TYPE      lsbVal
    );
        operand_t res;
        res.pend = pend;
        res.val  = val;
        if (pend) begin
            if (aluV && aluTag == tag) begin
                res.pend = FALSE;
                res.val  = aluVal;
            end
            if (lsbV && lsbTag == tag) begin
                res.pend = FALSE;
                res.val  = lsbVal;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers dispatched ALU ops, wakes operands from
// the ALU/LSB broadcasts and issues the lowest-index ready entry each cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          clr_in,
    input  logic          dispatch_valid,
    input  OPENUM_TYPE    dispatch_op,
    input  OP_TYPE        dispatch_opType,
    input  DATA_TYPE      dispatch_vj,
    input  logic          dispatch_qj_pend,
    input  ROB_INDEX_TYPE dispatch_qj,
    input  DATA_TYPE      dispatch_vk,
    input  logic          dispatch_qk_pend,
    input  ROB_INDEX_TYPE dispatch_qk,
    input  ROB_INDEX_TYPE dispatch_rob_index,
    input  ADDR_TYPE      dispatch_PC,
    input  DATA_TYPE      dispatch_imm,
    input  logic          alu_ready,
    input  ROB_INDEX_TYPE alu_rob_index,
    input  DATA_TYPE      alu_result,
    input  logic          lsb_ready,
    input  ROB_INDEX_TYPE lsb_rob_index,
    input  DATA_TYPE      lsb_result,
    output logic          rs_full,
    output logic          rs_to_alu_ready,
    output OPENUM_TYPE    rs_to_alu_op,
    output OP_TYPE        rs_to_alu_opType,
    output DATA_TYPE      rs_to_alu_rs1,
    output DATA_TYPE      rs_to_alu_rs2,
    output ROB_INDEX_TYPE rs_to_alu_rob_index,
    output ADDR_TYPE      rs_to_alu_PC,
    output DATA_TYPE      rs_to_alu_imm
);

    rs_entry_t     r_entries [RS_SIZE];
    logic          r_outReady;
    OPENUM_TYPE    r_outOp;
    OP_TYPE        r_outOpType;
    DATA_TYPE      r_outRs1;
    DATA_TYPE      r_outRs2;
    ROB_INDEX_TYPE r_outRob;
    ADDR_TYPE      r_outPc;
    DATA_TYPE      r_outImm;

    rs_entry_t     w_next [RS_SIZE];
    rs_entry_t     w_dispEntry;
    rs_entry_t     w_issueEntry;
    operand_t      w_wakeJ [RS_SIZE];
    operand_t      w_wakeK [RS_SIZE];
    operand_t      w_dispJ;
    operand_t      w_dispK;
    logic [RS_SIZE-1:0]  w_busy;
    logic [RS_SIZE-1:0]  w_ready;
    logic                w_freeFound;
    logic [RS_IDX_W-1:0] w_freeIdx;
    logic                w_readyFound;
    logic [RS_IDX_W-1:0] w_readyIdx;
    logic                w_dispAccept;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_busy[i]  = r_entries[i].busy;
            w_ready[i] = r_entries[i].busy && !r_entries[i].qj_pend && !r_entries[i].qk_pend;
            w_wakeJ[i] = snoop(r_entries[i].qj_pend, r_entries[i].vj, r_entries[i].qj,
                               alu_ready, alu_rob_index, alu_result,
                               lsb_ready, lsb_rob_index, lsb_result);
            w_wakeK[i] = snoop(r_entries[i].qk_pend, r_entries[i].vk, r_entries[i].qk,
                               alu_ready, alu_rob_index, alu_result,
                               lsb_ready, lsb_rob_index, lsb_result);
        end
    end

    rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_freeSelect (
        .i_req   (~w_busy),
        .o_found (w_freeFound),
        .o_idx   (w_freeIdx)
    );

    rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_readySelect (
        .i_req   (w_ready),
        .o_found (w_readyFound),
        .o_idx   (w_readyIdx)
    );

    assign rs_full      = &w_busy;
    assign w_dispAccept = dispatch_valid && !rs_full && w_freeFound;
    assign w_issueEntry = r_entries[w_readyIdx];

    // Same-cycle forwarding lets an operand produced in the dispatch cycle skip the wait.
    always_comb begin
        w_dispJ = snoop(dispatch_qj_pend, dispatch_vj, dispatch_qj,
                        alu_ready, alu_rob_index, alu_result,
                        lsb_ready, lsb_rob_index, lsb_result);
        w_dispK = snoop(dispatch_qk_pend, dispatch_vk, dispatch_qk,
                        alu_ready, alu_rob_index, alu_result,
                        lsb_ready, lsb_rob_index, lsb_result);
        w_dispEntry.busy    = TRUE;
        w_dispEntry.op      = dispatch_op;
        w_dispEntry.opType  = dispatch_opType;
        w_dispEntry.vj      = w_dispJ.val;
        w_dispEntry.qj_pend = w_dispJ.pend;
        w_dispEntry.qj      = dispatch_qj;
        w_dispEntry.vk      = w_dispK.val;
        w_dispEntry.qk_pend = w_dispK.pend;
        w_dispEntry.qk      = dispatch_qk;
        w_dispEntry.rob     = dispatch_rob_index;
        w_dispEntry.pc      = dispatch_PC;
        w_dispEntry.imm     = dispatch_imm;
    end

    // The free slot is never the issuing slot, so dispatch and issue never touch the same entry.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_next[i]         = r_entries[i];
            w_next[i].qj_pend = w_wakeJ[i].pend;
            w_next[i].vj      = w_wakeJ[i].val;
            w_next[i].qk_pend = w_wakeK[i].pend;
            w_next[i].vk      = w_wakeK[i].val;
            if (w_readyFound && w_readyIdx == RS_IDX_W'(i)) begin
                w_next[i].busy = FALSE;
            end
            if (w_dispAccept && w_freeIdx == RS_IDX_W'(i)) begin
                w_next[i] = w_dispEntry;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entries[i] <= '0;
            end
            r_outReady  <= FALSE;
            r_outOp     <= '0;
            r_outOpType <= '0;
            r_outRs1    <= '0;
            r_outRs2    <= '0;
            r_outRob    <= '0;
            r_outPc     <= '0;
            r_outImm    <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_entries[i].busy <= FALSE;
                end
                r_outReady <= FALSE;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_entries[i] <= w_next[i];
                end
                r_outReady <= w_readyFound;
                if (w_readyFound) begin
                    r_outOp     <= w_issueEntry.op;
                    r_outOpType <= w_issueEntry.opType;
                    r_outRs1    <= w_issueEntry.vj;
                    r_outRs2    <= w_issueEntry.vk;
                    r_outRob    <= w_issueEntry.rob;
                    r_outPc     <= w_issueEntry.pc;
                    r_outImm    <= w_issueEntry.imm;
                end
            end
        end
    end

    assign rs_to_alu_ready     = r_outReady;
    assign rs_to_alu_op        = r_outOp;
    assign rs_to_alu_opType    = r_outOpType;
    assign rs_to_alu_rs1       = r_outRs1;
    assign rs_to_alu_rs2       = r_outRs2;
    assign rs_to_alu_rob_index = r_outRob;
    assign rs_to_alu_PC        = r_outPc;
    assign rs_to_alu_imm       = r_outImm;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a vector table for single-op issue and
// forwarding, plus hand sequences for wakeup, full, flush, stall and reset.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clr_in;
    logic        dispatch_valid;
    logic [5:0]  dispatch_op;
    logic [3:0]  dispatch_opType;
    logic [31:0] dispatch_vj;
    logic        dispatch_qj_pend;
    logic [3:0]  dispatch_qj;
    logic [31:0] dispatch_vk;
    logic        dispatch_qk_pend;
    logic [3:0]  dispatch_qk;
    logic [3:0]  dispatch_rob_index;
    logic [31:0] dispatch_PC;
    logic [31:0] dispatch_imm;
    logic        alu_ready;
    logic [3:0]  alu_rob_index;
    logic [31:0] alu_result;
    logic        lsb_ready;
    logic [3:0]  lsb_rob_index;
    logic [31:0] lsb_result;
    logic        rs_full;
    logic        rs_to_alu_ready;
    logic [5:0]  rs_to_alu_op;
    logic [3:0]  rs_to_alu_opType;
    logic [31:0] rs_to_alu_rs1;
    logic [31:0] rs_to_alu_rs2;
    logic [3:0]  rs_to_alu_rob_index;
    logic [31:0] rs_to_alu_PC;
    logic [31:0] rs_to_alu_imm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  opType;
        logic [31:0] vj;
        logic        qjP;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic        qkP;
        logic [3:0]  qk;
        logic [3:0]  rob;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        aluV;
        logic [3:0]  aluTag;
        logic [31:0] aluRes;
        logic        lsbV;
        logic [3:0]  lsbTag;
        logic [31:0] lsbRes;
        logic [31:0] expRs1;
        logic [31:0] expRs2;
    } vec_t;

    vec_t vecs [7];

    reservation_station dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .rdy_in              (rdy_in),
        .clr_in              (clr_in),
        .dispatch_valid      (dispatch_valid),
        .dispatch_op         (dispatch_op),
        .dispatch_opType     (dispatch_opType),
        .dispatch_vj         (dispatch_vj),
        .dispatch_qj_pend    (dispatch_qj_pend),
        .dispatch_qj         (dispatch_qj),
        .dispatch_vk         (dispatch_vk),
        .dispatch_qk_pend    (dispatch_qk_pend),
        .dispatch_qk         (dispatch_qk),
        .dispatch_rob_index  (dispatch_rob_index),
        .dispatch_PC         (dispatch_PC),
        .dispatch_imm        (dispatch_imm),
        .alu_ready           (alu_ready),
        .alu_rob_index       (alu_rob_index),
        .alu_result          (alu_result),
        .lsb_ready           (lsb_ready),
        .lsb_rob_index       (lsb_rob_index),
        .lsb_result          (lsb_result),
        .rs_full             (rs_full),
        .rs_to_alu_ready     (rs_to_alu_ready),
        .rs_to_alu_op        (rs_to_alu_op),
        .rs_to_alu_opType    (rs_to_alu_opType),
        .rs_to_alu_rs1       (rs_to_alu_rs1),
        .rs_to_alu_rs2       (rs_to_alu_rs2),
        .rs_to_alu_rob_index (rs_to_alu_rob_index),
        .rs_to_alu_PC        (rs_to_alu_PC),
        .rs_to_alu_imm       (rs_to_alu_imm)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idleInputs();
        dispatch_valid     = 1'b0;
        dispatch_op        = '0;
        dispatch_opType    = '0;
        dispatch_vj        = '0;
        dispatch_qj_pend   = 1'b0;
        dispatch_qj        = '0;
        dispatch_vk        = '0;
        dispatch_qk_pend   = 1'b0;
        dispatch_qk        = '0;
        dispatch_rob_index = '0;
        dispatch_PC        = '0;
        dispatch_imm       = '0;
        alu_ready          = 1'b0;
        alu_rob_index      = '0;
        alu_result         = '0;
        lsb_ready          = 1'b0;
        lsb_rob_index      = '0;
        lsb_result         = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        dispatch_valid     = 1'b1;
        dispatch_op        = v.op;
        dispatch_opType    = v.opType;
        dispatch_vj        = v.vj;
        dispatch_qj_pend   = v.qjP;
        dispatch_qj        = v.qj;
        dispatch_vk        = v.vk;
        dispatch_qk_pend   = v.qkP;
        dispatch_qk        = v.qk;
        dispatch_rob_index = v.rob;
        dispatch_PC        = v.pc;
        dispatch_imm       = v.imm;
        alu_ready          = v.aluV;
        alu_rob_index      = v.aluTag;
        alu_result         = v.aluRes;
        lsb_ready          = v.lsbV;
        lsb_rob_index      = v.lsbTag;
        lsb_result         = v.lsbRes;
    endtask

    task automatic dispatchSimple(input logic [31:0] vj, input logic qjP, input logic [3:0] qj,
                                  input logic [31:0] vk, input logic [3:0] rob);
        idleInputs();
        dispatch_valid     = 1'b1;
        dispatch_op        = 6'd9;
        dispatch_opType    = 4'd1;
        dispatch_vj        = vj;
        dispatch_qj_pend   = qjP;
        dispatch_qj        = qj;
        dispatch_vk        = vk;
        dispatch_rob_index = rob;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    initial begin
        //           op     ty    vj            qjP  qj  vk        qkP  qk  rob  pc         imm        aluV tag res           lsbV tag res        expRs1        expRs2
        vecs[0] = '{6'd1, 4'd1, 32'd5,        0, 4'd0, 32'd7,    0, 4'd0, 4'd3,  32'h0,     32'h0,     0, 4'd0, 32'h0,      0, 4'd0, 32'h0,     32'd5,        32'd7};
        vecs[1] = '{6'd2, 4'd2, 32'hFFFFFFFF, 0, 4'd0, 32'd0,    0, 4'd0, 4'd15, 32'h100,   32'h800,   0, 4'd0, 32'h0,      0, 4'd0, 32'h0,     32'hFFFFFFFF, 32'd0};
        vecs[2] = '{6'd3, 4'd1, 32'd0,        1, 4'd6, 32'd9,    0, 4'd0, 4'd4,  32'h4,     32'h0,     0, 4'd0, 32'h0,      1, 4'd6, 32'hAB,    32'hAB,       32'd9};
        vecs[3] = '{6'd4, 4'd1, 32'h11,       0, 4'd0, 32'd0,    1, 4'd1, 4'd5,  32'h8,     32'h3,     1, 4'd1, 32'h1234,   0, 4'd0, 32'h0,     32'h11,       32'h1234};
        vecs[4] = '{6'd5, 4'd3, 32'd0,        1, 4'd2, 32'd0,    1, 4'd3, 4'd6,  32'hC,     32'h4,     1, 4'd2, 32'h22,     1, 4'd3, 32'h33,    32'h22,       32'h33};
        vecs[5] = '{6'd6, 4'd1, 32'd0,        1, 4'd4, 32'h77,   0, 4'd0, 4'd7,  32'h10,    32'h5,     1, 4'd4, 32'h1,      1, 4'd4, 32'h2,     32'h2,        32'h77};
        vecs[6] = '{6'd7, 4'd2, 32'h99,       0, 4'd8, 32'h66,   0, 4'd0, 4'd8,  32'h14,    32'h6,     1, 4'd8, 32'h55,     0, 4'd0, 32'h0,     32'h99,       32'h66};

        idleInputs();
        rdy_in   = 1'b1;
        clr_in   = 1'b0;
        rst_n_in = 1'b0;
        #2;
        checkOutput("reset_ready", {31'd0, rs_to_alu_ready}, 32'd0);
        checkOutput("reset_full", {31'd0, rs_full}, 32'd0);
        checkOutput("reset_rs1", rs_to_alu_rs1, 32'd0);
        step();
        step();
        rst_n_in = 1'b1;
        step();

        // Table: single dispatch, issue after the following edge, pulse gone one edge later.
        for (int n = 0; n < 7; n++) begin
            applyStimulus(vecs[n]);
            step();
            idleInputs();
            checkOutput($sformatf("v%0d_no_early_issue", n), {31'd0, rs_to_alu_ready}, 32'd0);
            step();
            checkOutput($sformatf("v%0d_ready", n), {31'd0, rs_to_alu_ready}, 32'd1);
            checkOutput($sformatf("v%0d_rs1", n), rs_to_alu_rs1, vecs[n].expRs1);
            checkOutput($sformatf("v%0d_rs2", n), rs_to_alu_rs2, vecs[n].expRs2);
            checkOutput($sformatf("v%0d_rob", n), {28'd0, rs_to_alu_rob_index}, {28'd0, vecs[n].rob});
            checkOutput($sformatf("v%0d_op", n), {26'd0, rs_to_alu_op}, {26'd0, vecs[n].op});
            checkOutput($sformatf("v%0d_opType", n), {28'd0, rs_to_alu_opType}, {28'd0, vecs[n].opType});
            checkOutput($sformatf("v%0d_pc", n), rs_to_alu_PC, vecs[n].pc);
            checkOutput($sformatf("v%0d_imm", n), rs_to_alu_imm, vecs[n].imm);
            step();
            checkOutput($sformatf("v%0d_pulse_end", n), {31'd0, rs_to_alu_ready}, 32'd0);
        end

        // Wakeup from a later ALU broadcast.
        dispatchSimple(32'd0, 1'b1, 4'd2, 32'd1, 4'd10);
        step();
        idleInputs();
        step();
        checkOutput("wake_pending_no_issue", {31'd0, rs_to_alu_ready}, 32'd0);
        alu_ready     = 1'b1;
        alu_rob_index = 4'd2;
        alu_result    = 32'h10;
        step();
        idleInputs();
        checkOutput("wake_edge_no_issue", {31'd0, rs_to_alu_ready}, 32'd0);
        step();
        checkOutput("wake_ready", {31'd0, rs_to_alu_ready}, 32'd1);
        checkOutput("wake_rs1", rs_to_alu_rs1, 32'h10);
        checkOutput("wake_rs2", rs_to_alu_rs2, 32'd1);
        checkOutput("wake_rob", {28'd0, rs_to_alu_rob_index}, 32'd10);
        step();
        checkOutput("wake_pulse_end", {31'd0, rs_to_alu_ready}, 32'd0);

        // Fill all 16 entries pending on tag 5, then try a 17th ready dispatch.
        for (int i = 0; i < 16; i++) begin
            dispatchSimple(32'd0, 1'b1, 4'd5, 32'd100 + 32'(i), 4'(i));
            step();
        end
        idleInputs();
        checkOutput("full_flag", {31'd0, rs_full}, 32'd1);
        dispatchSimple(32'hDEAD, 1'b0, 4'd0, 32'hBEEF, 4'd12);
        step();
        idleInputs();
        step();
        checkOutput("full_drop_no_issue", {31'd0, rs_to_alu_ready}, 32'd0);
        checkOutput("full_still_full", {31'd0, rs_full}, 32'd1);
        alu_ready     = 1'b1;
        alu_rob_index = 4'd5;
        alu_result    = 32'h500;
        step();
        idleInputs();
        for (int i = 0; i < 16; i++) begin
            step();
            checkOutput($sformatf("drain%0d_ready", i), {31'd0, rs_to_alu_ready}, 32'd1);
            checkOutput($sformatf("drain%0d_rob", i), {28'd0, rs_to_alu_rob_index}, 32'(i));
            checkOutput($sformatf("drain%0d_rs1", i), rs_to_alu_rs1, 32'h500);
            checkOutput($sformatf("drain%0d_rs2", i), rs_to_alu_rs2, 32'd100 + 32'(i));
        end
        step();
        checkOutput("drain_done_ready", {31'd0, rs_to_alu_ready}, 32'd0);
        checkOutput("drain_done_full", {31'd0, rs_full}, 32'd0);

        // Flush discards pending entries.
        for (int i = 0; i < 4; i++) begin
            dispatchSimple(32'd0, 1'b1, 4'd9, 32'd0, 4'(i));
            step();
        end
        idleInputs();
        clr_in = 1'b1;
        step();
        clr_in = 1'b0;
        checkOutput("flush_full", {31'd0, rs_full}, 32'd0);
        checkOutput("flush_ready", {31'd0, rs_to_alu_ready}, 32'd0);
        alu_ready     = 1'b1;
        alu_rob_index = 4'd9;
        alu_result    = 32'h9;
        step();
        idleInputs();
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("flush_no_issue%0d", i), {31'd0, rs_to_alu_ready}, 32'd0);
        end

        // Stall: a ready entry waits out rdy_in=0, and a dispatch offered during the stall is ignored.
        dispatchSimple(32'h55, 1'b0, 4'd0, 32'h66, 4'd7);
        step();
        dispatchSimple(32'hAA, 1'b0, 4'd0, 32'hBB, 4'd8);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("stall%0d_ready", i), {31'd0, rs_to_alu_ready}, 32'd0);
        end
        idleInputs();
        rdy_in = 1'b1;
        step();
        checkOutput("stall_release_ready", {31'd0, rs_to_alu_ready}, 32'd1);
        checkOutput("stall_release_rs1", rs_to_alu_rs1, 32'h55);
        rdy_in = 1'b0;
        step();
        checkOutput("stall_hold_pulse", {31'd0, rs_to_alu_ready}, 32'd1);
        checkOutput("stall_hold_rob", {28'd0, rs_to_alu_rob_index}, 32'd7);
        rdy_in = 1'b1;
        step();
        checkOutput("stall_pulse_end", {31'd0, rs_to_alu_ready}, 32'd0);
        step();
        checkOutput("stall_dispatch_ignored", {31'd0, rs_to_alu_ready}, 32'd0);

        // Asynchronous reset mid-stream wipes an entry that has not issued yet.
        dispatchSimple(32'h1, 1'b0, 4'd0, 32'h2, 4'd1);
        step();
        dispatchSimple(32'h3, 1'b0, 4'd0, 32'h4, 4'd2);
        step();
        idleInputs();
        checkOutput("pre_reset_ready", {31'd0, rs_to_alu_ready}, 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_reset_ready", {31'd0, rs_to_alu_ready}, 32'd0);
        checkOutput("async_reset_rs1", rs_to_alu_rs1, 32'd0);
        checkOutput("async_reset_full", {31'd0, rs_full}, 32'd0);
        step();
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("post_reset_idle%0d", i), {31'd0, rs_to_alu_ready}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
